// File: rtl/instruction_decode_pkg.sv
// Shared LEGv8 decode constants, ALU encodings and the ID/EX payload layout.
package instruction_decode_pkg;

  localparam int unsigned XLEN     = 64;
  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ALUOP_W  = 4;

  localparam logic [REG_AW-1:0] XZR = 5'd31;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_AND   = 4'b0000,
    ALU_ORR   = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_SUB   = 4'b0110,
    ALU_PASSB = 4'b0111
  } aluop_e;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic branch;
    logic uncond;
    logic alusrc;
    logic illegal;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rdata1;
    logic [XLEN-1:0]   rdata2;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rd;
    aluop_e            aluop;
    ctrl_t             ctrl;
  } idex_t;

endpackage

// File: rtl/register_file.sv
// 32x64 register file: two combinational read ports, one write port, X31 reads as zero.
module register_file
  import instruction_decode_pkg::*;
#(
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              resetl,
  input  logic [REG_AW-1:0] i_raddr1,
  input  logic [REG_AW-1:0] i_raddr2,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [XLEN-1:0]   i_wdata,
  output logic [XLEN-1:0]   o_rdata1_c,
  output logic [XLEN-1:0]   o_rdata2_c
);

  logic [XLEN-1:0] r_regs [NUM_REGS];

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (i_we && (i_waddr != XZR)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Same-cycle write-back forwarding; X31 always wins as zero.
  always_comb begin
    o_rdata1_c = r_regs[i_raddr1];
    if (i_raddr1 == XZR)                              o_rdata1_c = '0;
    else if (BYPASS && i_we && (i_waddr == i_raddr1)) o_rdata1_c = i_wdata;
  end

  always_comb begin
    o_rdata2_c = r_regs[i_raddr2];
    if (i_raddr2 == XZR)                              o_rdata2_c = '0;
    else if (BYPASS && i_we && (i_waddr == i_raddr2)) o_rdata2_c = i_wdata;
  end

endmodule

// File: rtl/instruction_decode.sv
// LEGv8 ID stage: decode, register read, load-use hazard detection and the ID/EX register.
module instruction_decode
  import instruction_decode_pkg::*;
#(
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic               clk,
  input  logic               resetl,
  input  logic [INSTR_W-1:0] instruction_ID,
  input  logic [XLEN-1:0]    pc_ID,
  input  logic               flush,
  input  logic               wb_we,
  input  logic [REG_AW-1:0]  wb_rd,
  input  logic [XLEN-1:0]    wb_data,
  output logic               pc_stall,
  output logic [XLEN-1:0]    pc_EX,
  output logic [XLEN-1:0]    rdata1_EX,
  output logic [XLEN-1:0]    rdata2_EX,
  output logic [XLEN-1:0]    imm_EX,
  output logic [REG_AW-1:0]  rd_EX,
  output logic [ALUOP_W-1:0] aluop_EX,
  output logic               regwrite_EX,
  output logic               memread_EX,
  output logic               memwrite_EX,
  output logic               branch_EX,
  output logic               uncond_EX,
  output logic               alusrc_EX,
  output logic               illegal_EX
);

  logic [10:0]       w_op11;
  logic [9:0]        w_op10;
  logic [7:0]        w_op8;
  logic [5:0]        w_op6;
  logic [REG_AW-1:0] w_rn;
  logic [REG_AW-1:0] w_rm;
  logic [REG_AW-1:0] w_rt;
  logic [REG_AW-1:0] w_r2;
  ctrl_t             w_ctrl;
  aluop_e            w_aluop;
  logic [XLEN-1:0]   w_imm;
  logic [REG_AW-1:0] w_rd;
  logic              w_use_rn;
  logic              w_use_r2;
  logic              w_r2_rt;
  logic              w_legal;
  logic              w_hazard;
  logic [XLEN-1:0]   w_rdata1;
  logic [XLEN-1:0]   w_rdata2;
  idex_t             w_next;
  idex_t             r_idex;

  assign w_op11 = instruction_ID[31:21];
  assign w_op10 = instruction_ID[31:22];
  assign w_op8  = instruction_ID[31:24];
  assign w_op6  = instruction_ID[31:26];
  assign w_rn   = instruction_ID[9:5];
  assign w_rm   = instruction_ID[20:16];
  assign w_rt   = instruction_ID[4:0];
  assign w_r2   = w_r2_rt ? w_rt : w_rm;

  // Opcode decode; instructions with no destination report XZR as rd.
  always_comb begin
    w_ctrl   = '0;
    w_aluop  = ALU_AND;
    w_imm    = '0;
    w_rd     = XZR;
    w_use_rn = 1'b0;
    w_use_r2 = 1'b0;
    w_r2_rt  = 1'b0;
    w_legal  = 1'b1;
    if ((w_op11 == OP_ADD) || (w_op11 == OP_SUB) ||
        (w_op11 == OP_AND) || (w_op11 == OP_ORR)) begin
      w_ctrl.regwrite = 1'b1;
      w_rd            = w_rt;
      w_use_rn        = 1'b1;
      w_use_r2        = 1'b1;
      case (w_op11)
        OP_SUB:  w_aluop = ALU_SUB;
        OP_AND:  w_aluop = ALU_AND;
        OP_ORR:  w_aluop = ALU_ORR;
        default: w_aluop = ALU_ADD;
      endcase
    end else if (w_op11 == OP_LDUR) begin
      w_ctrl.regwrite = 1'b1;
      w_ctrl.memread  = 1'b1;
      w_ctrl.alusrc   = 1'b1;
      w_aluop         = ALU_ADD;
      w_imm           = XLEN'($signed(instruction_ID[20:12]));
      w_rd            = w_rt;
      w_use_rn        = 1'b1;
    end else if (w_op11 == OP_STUR) begin
      w_ctrl.memwrite = 1'b1;
      w_ctrl.alusrc   = 1'b1;
      w_aluop         = ALU_ADD;
      w_imm           = XLEN'($signed(instruction_ID[20:12]));
      w_use_rn        = 1'b1;
      w_use_r2        = 1'b1;
      w_r2_rt         = 1'b1;
    end else if ((w_op10 == OP_ADDI) || (w_op10 == OP_SUBI)) begin
      w_ctrl.regwrite = 1'b1;
      w_ctrl.alusrc   = 1'b1;
      w_aluop         = (w_op10 == OP_SUBI) ? ALU_SUB : ALU_ADD;
      w_imm           = XLEN'(instruction_ID[21:10]);
      w_rd            = w_rt;
      w_use_rn        = 1'b1;
    end else if (w_op8 == OP_CBZ) begin
      w_ctrl.branch = 1'b1;
      w_aluop       = ALU_PASSB;
      w_imm         = XLEN'($signed(instruction_ID[23:5])) << 2;
      w_use_r2      = 1'b1;
      w_r2_rt       = 1'b1;
    end else if (w_op6 == OP_B) begin
      w_ctrl.uncond = 1'b1;
      w_imm         = XLEN'($signed(instruction_ID[25:0])) << 2;
    end else begin
      w_legal = 1'b0;
    end
  end

  register_file #(
    .BYPASS (WB_BYPASS)
  ) u_register_file (
    .clk        (clk),
    .resetl     (resetl),
    .i_raddr1   (w_rn),
    .i_raddr2   (w_r2),
    .i_we       (wb_we),
    .i_waddr    (wb_rd),
    .i_wdata    (wb_data),
    .o_rdata1_c (w_rdata1),
    .o_rdata2_c (w_rdata2)
  );

  // Load-use: only sources the instruction actually reads can trigger a stall.
  assign w_hazard = r_idex.ctrl.memread && (r_idex.rd != XZR) &&
                    ((w_use_rn && (w_rn == r_idex.rd)) || (w_use_r2 && (w_r2 == r_idex.rd)));
  assign pc_stall = w_hazard && !flush;

  always_comb begin
    w_next    = '0;
    w_next.rd = XZR;
    if (flush || pc_stall) begin
      w_next.rd = XZR;
    end else if (!w_legal) begin
      w_next.pc           = pc_ID;
      w_next.ctrl.illegal = 1'b1;
    end else begin
      w_next.pc     = pc_ID;
      w_next.rdata1 = w_rdata1;
      w_next.rdata2 = w_rdata2;
      w_next.imm    = w_imm;
      w_next.rd     = w_rd;
      w_next.aluop  = w_aluop;
      w_next.ctrl   = w_ctrl;
    end
  end

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) r_idex <= '0;
    else         r_idex <= w_next;
  end

  assign pc_EX       = r_idex.pc;
  assign rdata1_EX   = r_idex.rdata1;
  assign rdata2_EX   = r_idex.rdata2;
  assign imm_EX      = r_idex.imm;
  assign rd_EX       = r_idex.rd;
  assign aluop_EX    = r_idex.aluop;
  assign regwrite_EX = r_idex.ctrl.regwrite;
  assign memread_EX  = r_idex.ctrl.memread;
  assign memwrite_EX = r_idex.ctrl.memwrite;
  assign branch_EX   = r_idex.ctrl.branch;
  assign uncond_EX   = r_idex.ctrl.uncond;
  assign alusrc_EX   = r_idex.ctrl.alusrc;
  assign illegal_EX  = r_idex.ctrl.illegal;

endmodule

// File: tb/tb_instruction_decode.sv
// Scoreboard bench for instruction_decode: expected ID/EX contents queued at drive time, popped after the edge.
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        resetl;
  logic [31:0] instruction_ID;
  logic [63:0] pc_ID;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        pc_stall;
  logic [63:0] pc_EX, rdata1_EX, rdata2_EX, imm_EX;
  logic [4:0]  rd_EX;
  logic [3:0]  aluop_EX;
  logic        regwrite_EX, memread_EX, memwrite_EX, branch_EX, uncond_EX, alusrc_EX, illegal_EX;

  instruction_decode #(.WB_BYPASS(1'b1)) dut (
    .clk(clk), .resetl(resetl), .instruction_ID(instruction_ID), .pc_ID(pc_ID),
    .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .pc_stall(pc_stall),
    .pc_EX(pc_EX), .rdata1_EX(rdata1_EX), .rdata2_EX(rdata2_EX), .imm_EX(imm_EX),
    .rd_EX(rd_EX), .aluop_EX(aluop_EX), .regwrite_EX(regwrite_EX), .memread_EX(memread_EX),
    .memwrite_EX(memwrite_EX), .branch_EX(branch_EX), .uncond_EX(uncond_EX),
    .alusrc_EX(alusrc_EX), .illegal_EX(illegal_EX)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc; logic [63:0] r1; logic [63:0] r2; logic [63:0] imm;
    logic [4:0] rd; logic [3:0] aluop; logic [6:0] ctl;  // {rw,mr,mw,br,un,as,il}
  } idex_t;

  typedef struct {
    logic [31:0] ins; logic [63:0] pc; logic fl;
    logic we; logic [4:0] wrd; logic [63:0] wd;
    logic stall; idex_t exp;
  } step_t;

  localparam logic [6:0] C_R = 7'b1000000, C_LD = 7'b1100010, C_ST = 7'b0010010, C_IMM = 7'b1000010,
                         C_CBZ = 7'b0001000, C_B = 7'b0000100, C_ILL = 7'b0000001;
  localparam logic [3:0] A_ADD = 4'b0010, A_SUB = 4'b0110, A_AND = 4'b0000, A_ORR = 4'b0001, A_PB = 4'b0111;

  localparam logic [31:0] I_ADD3   = 32'h8B020023;  // ADD X3,X1,X2
  localparam logic [31:0] I_ADD4Z  = 32'h8B0203E4;  // ADD X4,XZR,X2
  localparam logic [31:0] I_SUB7   = 32'hCB010047;  // SUB X7,X2,X1
  localparam logic [31:0] I_AND8   = 32'h8A020028;  // AND X8,X1,X2
  localparam logic [31:0] I_ORR9   = 32'hAA020029;  // ORR X9,X1,X2
  localparam logic [31:0] I_LDUR1  = 32'hF8408041;  // LDUR X1,[X2,#8]
  localparam logic [31:0] I_LDURZ  = 32'hF840805F;  // LDUR XZR,[X2,#8]
  localparam logic [31:0] I_STUR1  = 32'hF81FF041;  // STUR X1,[X2,#-1]
  localparam logic [31:0] I_ADDI   = 32'h913FFC26;  // ADDI X6,X1,#4095
  localparam logic [31:0] I_SUBI   = 32'hD1000426;  // SUBI X6,X1,#1
  localparam logic [31:0] I_CBZ5   = 32'hB4FFFFC5;  // CBZ X5,#-2
  localparam logic [31:0] I_BP3    = 32'h14000003;  // B #3
  localparam logic [31:0] I_BM1    = 32'h17FFFFFF;  // B #-1
  localparam logic [31:0] I_BAD    = 32'hFFFFFFFF;

  idex_t obs;
  assign obs = {pc_EX, rdata1_EX, rdata2_EX, imm_EX, rd_EX, aluop_EX,
                regwrite_EX, memread_EX, memwrite_EX, branch_EX, uncond_EX, alusrc_EX, illegal_EX};

  idex_t exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic idex_t mk(logic [63:0] pc, logic [63:0] r1, logic [63:0] r2, logic [63:0] imm,
                               logic [4:0] rd, logic [3:0] op, logic [6:0] ctl);
    return {pc, r1, r2, imm, rd, op, ctl};
  endfunction

  function automatic idex_t bubble();
    return mk(64'd0, 64'd0, 64'd0, 64'd0, 5'd31, 4'd0, 7'd0);
  endfunction

  function automatic step_t st(logic [31:0] ins, logic [63:0] pc, logic fl, logic we, logic [4:0] wrd,
                               logic [63:0] wd, logic stall, idex_t e);
    step_t s;
    s.ins = ins; s.pc = pc; s.fl = fl; s.we = we; s.wrd = wrd; s.wd = wd; s.stall = stall; s.exp = e;
    return s;
  endfunction

  task automatic test_reset();
    idex_t z;
    z = '0;
    resetl = 1'b0; instruction_ID = I_ADD3; pc_ID = 64'h40; flush = 1'b0;
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (obs !== z) begin errors++; $display("FAIL reset idex got %h exp %h", obs, z); end
    checks++; if (pc_stall !== 1'b0) begin errors++; $display("FAIL reset pc_stall got %b exp 0", pc_stall); end
    @(negedge clk) resetl = 1'b1;
  endtask

  task automatic test_preload();
    step_t s[3];
    idex_t got, e;
    s[0] = st(32'h0, 64'h10, 1'b1, 1'b1, 5'd1, 64'd5,    1'b0, bubble());
    s[1] = st(32'h0, 64'h14, 1'b1, 1'b1, 5'd2, 64'd7,    1'b0, bubble());
    s[2] = st(32'h0, 64'h18, 1'b1, 1'b1, 5'd5, 64'h55,   1'b0, bubble());
    foreach (s[i]) begin
      instruction_ID = s[i].ins; pc_ID = s[i].pc; flush = s[i].fl;
      wb_we = s[i].we; wb_rd = s[i].wrd; wb_data = s[i].wd;
      #1;
      checks++; if (pc_stall !== s[i].stall) begin errors++; $display("FAIL preload[%0d] pc_stall got %b exp %b", i, pc_stall, s[i].stall); end
      exp_q.push_back(s[i].exp);
      @(posedge clk); #1;
      got = obs; e = exp_q.pop_front();
      checks++; if (got !== e) begin errors++; $display("FAIL preload[%0d] idex got %h exp %h", i, got, e); end
    end
  endtask

  task automatic test_alu_ops();
    step_t s[4];
    idex_t got, e;
    s[0] = st(I_ADD3, 64'h100, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, mk(64'h100, 64'd5, 64'd7, 64'd0, 5'd3, A_ADD, C_R));
    s[1] = st(I_SUB7, 64'h104, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, mk(64'h104, 64'd7, 64'd5, 64'd0, 5'd7, A_SUB, C_R));
    s[2] = st(I_AND8, 64'h108, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, mk(64'h108, 64'd5, 64'd7, 64'd0, 5'd8, A_AND, C_R));
    s[3] = st(I_ORR9, 64'h10C, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, mk(64'h10C, 64'd5, 64'd7, 64'd0, 5'd9, A_ORR, C_R));
    foreach (s[i]) begin
      instruction_ID = s[i].ins; pc_ID = s[i].pc; flush = s[i].fl;
      wb_we = s[i].we; wb_rd = s[i].wrd; wb_data = s[i].wd;
      #1;
      checks++; if (pc_stall !== s[i].stall) begin errors++; $display("FAIL alu[%0d] pc_stall got %b exp %b", i, pc_stall, s[i].stall); end
      exp_q.push_back(s[i].exp);
      @(posedge clk); #1;
      got = obs; e = exp_q.pop_front();
      checks++; if (got !== e) begin errors++; $display("FAIL alu[%0d] idex got %h exp %h", i, got, e); end
    end
  endtask

  task automatic test_imm_types();
    step_t s[4];
    idex_t got, e;
    s[0] = st(I_ADDI, 64'h180, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, mk(64'h180, 64'd5, 64'd0, 64'hFFF, 5'd6, A_ADD, C_IMM));
    s[1] = st(I_SUBI, 64'h184, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, mk(64'h184, 64'd5, 64'd0, 64'd1, 5'd6, A_SUB, C_IMM));
    s[2] = st(I_CBZ5, 64'h188, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0,
              mk(64'h188, 64'd0, 64'h55, 64'hFFFF_FFFF_FFFF_FFF8, 5'd31, A_PB, C_CBZ));
    s[3] = st(I_BM1,  64'h18C, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0,
              mk(64'h18C, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 5'd31, 4'd0, C_B));
    foreach (s[i]) begin
      instruction_ID = s[i].ins; pc_ID = s[i].pc; flush = s[i].fl;
      wb_we = s[i].we; wb_rd = s[i].wrd; wb_data = s[i].wd;
      #1;
      checks++; if (pc_stall !== s[i].stall) begin errors++; $display("FAIL imm[%0d] pc_stall got %b exp %b", i, pc_stall, s[i].stall); end
      exp_q.push_back(s[i].exp);
      @(posedge clk); #1;
      got = obs; e = exp_q.pop_front();
      checks++; if (got !== e) begin errors++; $display("FAIL imm[%0d] idex got %h exp %h", i, got, e); end
    end
  endtask

  task automatic test_load_use(input logic flush_mid);
    step_t s[3];
    idex_t got, e;
    s[0] = st(I_LDUR1, 64'h200, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, mk(64'h200, 64'd7, 64'd0, 64'd8, 5'd1, A_ADD, C_LD));
    s[1] = st(I_ADD3,  64'h204, flush_mid, 1'b0, 5'd0, 64'd0, !flush_mid, bubble());
    s[2] = st(I_ADD3,  64'h204, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, mk(64'h204, 64'd5, 64'd7, 64'd0, 5'd3, A_ADD, C_R));
    foreach (s[i]) begin
      instruction_ID = s[i].ins; pc_ID = s[i].pc; flush = s[i].fl;
      wb_we = s[i].we; wb_rd = s[i].wrd; wb_data = s[i].wd;
      #1;
      checks++; if (pc_stall !== s[i].stall) begin errors++; $display("FAIL load_use(fl=%0b)[%0d] pc_stall got %b exp %b", flush_mid, i, pc_stall, s[i].stall); end
      exp_q.push_back(s[i].exp);
      @(posedge clk); #1;
      got = obs; e = exp_q.pop_front();
      checks++; if (got !== e) begin errors++; $display("FAIL load_use(fl=%0b)[%0d] idex got %h exp %h", flush_mid, i, got, e); end
    end
  endtask

  task automatic test_hazard_bounds();
    step_t s[7];
    idex_t got, e;
    s[0] = st(I_LDURZ, 64'h400, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, mk(64'h400, 64'd7, 64'd0, 64'd8, 5'd31, A_ADD, C_LD));
    s[1] = st(I_ADD4Z, 64'h404, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, mk(64'h404, 64'd0, 64'd7, 64'd0, 5'd4, A_ADD, C_R));
    s[2] = st(I_LDUR1, 64'h408, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, mk(64'h408, 64'd7, 64'd0, 64'd8, 5'd1, A_ADD, C_LD));
    s[3] = st(I_BP3,   64'h40C, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, mk(64'h40C, 64'd0, 64'd0, 64'd12, 5'd31, 4'd0, C_B));
    s[4] = st(I_LDUR1, 64'h410, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, mk(64'h410, 64'd7, 64'd0, 64'd8, 5'd1, A_ADD, C_LD));
    s[5] = st(I_STUR1, 64'h414, 1'b0, 1'b0, 5'd0, 64'd0, 1'b1, bubble());
    s[6] = st(I_STUR1, 64'h414, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0,
              mk(64'h414, 64'd7, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, A_ADD, C_ST));
    foreach (s[i]) begin
      instruction_ID = s[i].ins; pc_ID = s[i].pc; flush = s[i].fl;
      wb_we = s[i].we; wb_rd = s[i].wrd; wb_data = s[i].wd;
      #1;
      checks++; if (pc_stall !== s[i].stall) begin errors++; $display("FAIL hazard[%0d] pc_stall got %b exp %b", i, pc_stall, s[i].stall); end
      exp_q.push_back(s[i].exp);
      @(posedge clk); #1;
      got = obs; e = exp_q.pop_front();
      checks++; if (got !== e) begin errors++; $display("FAIL hazard[%0d] idex got %h exp %h", i, got, e); end
    end
  endtask

  task automatic test_bypass();
    step_t s[5];
    idex_t got, e;
    s[0] = st(I_ADD3,  64'h500, 1'b0, 1'b1, 5'd1,  64'hAB, 1'b0, mk(64'h500, 64'hAB, 64'd7, 64'd0, 5'd3, A_ADD, C_R));
    s[1] = st(I_ADD4Z, 64'h504, 1'b0, 1'b1, 5'd31, 64'hCD, 1'b0, mk(64'h504, 64'd0, 64'd7, 64'd0, 5'd4, A_ADD, C_R));
    s[2] = st(I_ADD4Z, 64'h508, 1'b0, 1'b0, 5'd0,  64'd0,  1'b0, mk(64'h508, 64'd0, 64'd7, 64'd0, 5'd4, A_ADD, C_R));
    s[3] = st(I_ADD3,  64'h50C, 1'b0, 1'b0, 5'd0,  64'd0,  1'b0, mk(64'h50C, 64'hAB, 64'd7, 64'd0, 5'd3, A_ADD, C_R));
    s[4] = st(I_ADD3,  64'h510, 1'b0, 1'b1, 5'd2,  64'h77, 1'b0, mk(64'h510, 64'hAB, 64'h77, 64'd0, 5'd3, A_ADD, C_R));
    foreach (s[i]) begin
      instruction_ID = s[i].ins; pc_ID = s[i].pc; flush = s[i].fl;
      wb_we = s[i].we; wb_rd = s[i].wrd; wb_data = s[i].wd;
      #1;
      checks++; if (pc_stall !== s[i].stall) begin errors++; $display("FAIL bypass[%0d] pc_stall got %b exp %b", i, pc_stall, s[i].stall); end
      exp_q.push_back(s[i].exp);
      @(posedge clk); #1;
      got = obs; e = exp_q.pop_front();
      checks++; if (got !== e) begin errors++; $display("FAIL bypass[%0d] idex got %h exp %h", i, got, e); end
    end
  endtask

  task automatic test_illegal();
    step_t s[2];
    idex_t got, e;
    s[0] = st(I_BAD, 64'h600, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, mk(64'h600, 64'd0, 64'd0, 64'd0, 5'd31, 4'd0, C_ILL));
    s[1] = st(I_BAD, 64'h604, 1'b1, 1'b0, 5'd0, 64'd0, 1'b0, bubble());
    foreach (s[i]) begin
      instruction_ID = s[i].ins; pc_ID = s[i].pc; flush = s[i].fl;
      wb_we = s[i].we; wb_rd = s[i].wrd; wb_data = s[i].wd;
      #1;
      checks++; if (pc_stall !== s[i].stall) begin errors++; $display("FAIL illegal[%0d] pc_stall got %b exp %b", i, pc_stall, s[i].stall); end
      exp_q.push_back(s[i].exp);
      @(posedge clk); #1;
      got = obs; e = exp_q.pop_front();
      checks++; if (got !== e) begin errors++; $display("FAIL illegal[%0d] idex got %h exp %h", i, got, e); end
    end
  endtask

  task automatic test_reset_midstream();
    idex_t got, e, z;
    z = '0;
    instruction_ID = I_LDUR1; pc_ID = 64'h700; flush = 1'b0; wb_we = 1'b0;
    exp_q.push_back(mk(64'h700, 64'h77, 64'd0, 64'd8, 5'd1, A_ADD, C_LD));
    @(posedge clk); #1;
    got = obs; e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL rst_mid ldur idex got %h exp %h", got, e); end
    instruction_ID = I_ADD3; pc_ID = 64'h704;
    #1;
    checks++; if (pc_stall !== 1'b1) begin errors++; $display("FAIL rst_mid pre pc_stall got %b exp 1", pc_stall); end
    resetl = 1'b0;
    #1;
    checks++; if (obs !== z) begin errors++; $display("FAIL rst_mid async idex got %h exp %h", obs, z); end
    checks++; if (pc_stall !== 1'b0) begin errors++; $display("FAIL rst_mid pc_stall got %b exp 0", pc_stall); end
    @(negedge clk) resetl = 1'b1;
    exp_q.push_back(mk(64'h704, 64'd0, 64'd0, 64'd0, 5'd3, A_ADD, C_R));
    @(posedge clk); #1;
    got = obs; e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL rst_mid post idex got %h exp %h", got, e); end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_alu_ops();
    test_imm_types();
    test_load_use(1'b0);
    test_load_use(1'b1);
    test_hazard_bounds();
    test_bypass();
    test_illegal();
    test_reset_midstream();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard leftover got %0d exp 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
